// File: rtl/div_sequencer_if.sv
// Handshake bundle between the division sequencer and its neighbours.
// Groups three links:
//   issue     : issue_new/issue_ready plus operands rs1, rs2, fn3, issue_id
//   divider   : div_start/div_dividend/div_divisor out, div_quotient/div_remainder/
//               div_done/div_divisor_is_zero in
//   writeback : wb_done/wb_id/wb_rd out, wb_ack in
// The master modport is the sequencer; the slave modport is the issue/divider/writeback side.
interface div_sequencer_if #(
   parameter int unsigned ID_WIDTH = 3
);
   localparam int unsigned XLEN = 32;

   logic                issue_new;
   logic                issue_ready;
   logic [XLEN-1:0]     rs1;
   logic [XLEN-1:0]     rs2;
   logic [1:0]          fn3;
   logic [ID_WIDTH-1:0] issue_id;

   logic                div_start;
   logic [XLEN-1:0]     div_dividend;
   logic [XLEN-1:0]     div_divisor;
   logic [XLEN-1:0]     div_quotient;
   logic [XLEN-1:0]     div_remainder;
   logic                div_done;
   logic                div_divisor_is_zero;

   logic                wb_done;
   logic [ID_WIDTH-1:0] wb_id;
   logic [XLEN-1:0]     wb_rd;
   logic                wb_ack;

   modport master (
      input  issue_new, rs1, rs2, fn3, issue_id,
      input  div_quotient, div_remainder, div_done, div_divisor_is_zero,
      input  wb_ack,
      output issue_ready, div_start, div_dividend, div_divisor,
      output wb_done, wb_id, wb_rd
   );

   modport slave (
      output issue_new, rs1, rs2, fn3, issue_id,
      output div_quotient, div_remainder, div_done, div_divisor_is_zero,
      output wb_ack,
      input  issue_ready, div_start, div_dividend, div_divisor,
      input  wb_done, wb_id, wb_rd
   );
endinterface

// File: rtl/div_sequencer.sv
// Issue-side sequencer for the shared unsigned iterative divider (DIV/DIVU/REM/REMU).
// Accepts one operation at a time, hands operand magnitudes to the divider with a
// one-cycle start pulse, sign-corrects the selected quotient/remainder and holds it on
// the writeback handshake until acknowledged. Divide-by-zero and signed overflow are
// answered directly without involving the divider.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - div_sequencer_if master: issue, divider and writeback handshakes
module div_sequencer #(
   parameter int unsigned ID_WIDTH = 3
) (
   input logic              clk,
   input logic              rst,
   div_sequencer_if.master  bus
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_RESULT
   } state_e;

   // Per-operation attributes needed after the divider returns
   typedef struct packed {
      logic is_rem;
      logic neg_q;
      logic neg_r;
   } op_t;

   state_e              state_q, state_d;
   op_t                 op_q, op_d;
   logic [XLEN-1:0]     dividend_q, dividend_d;
   logic [XLEN-1:0]     divisor_q, divisor_d;
   logic [XLEN-1:0]     wb_rd_q, wb_rd_d;
   logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;
   logic                ready_q, ready_d;
   logic                start_q, start_d;
   logic                done_q, done_d;

   logic                accept_c;
   logic                is_signed_c;
   logic                is_rem_c;
   logic                rs1_neg_c;
   logic                rs2_neg_c;
   logic [XLEN-1:0]     mag1_c;
   logic [XLEN-1:0]     mag2_c;
   logic                div_zero_c;
   logic                overflow_c;
   logic [XLEN-1:0]     bypass_val_c;
   logic [XLEN-1:0]     raw_res_c;
   logic                res_neg_c;
   logic [XLEN-1:0]     fixed_res_c;
   logic                unused_c;

   // The divider reports its own zero-divisor flag; the zero case is already resolved here
   assign unused_c = bus.div_divisor_is_zero;

   // Issue decode: fn3[0] selects unsigned, fn3[1] selects remainder
   assign accept_c    = bus.issue_new && ready_q;
   assign is_signed_c = ~bus.fn3[0];
   assign is_rem_c    = bus.fn3[1];
   assign rs1_neg_c   = is_signed_c & bus.rs1[XLEN-1];
   assign rs2_neg_c   = is_signed_c & bus.rs2[XLEN-1];

   // Magnitudes; INT_MIN negates to itself, which is its correct unsigned magnitude
   assign mag1_c = rs1_neg_c ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
   assign mag2_c = rs2_neg_c ? (~bus.rs2 + XLEN'(1)) : bus.rs2;

   // Cases answered without the divider
   assign div_zero_c = (bus.rs2 == '0);
   assign overflow_c = is_signed_c && (bus.rs1 == INT_MIN) && (bus.rs2 == ALL_ONES);

   always_comb begin
      bypass_val_c = '0;
      if (div_zero_c) begin
         bypass_val_c = is_rem_c ? bus.rs1 : ALL_ONES;
      end else if (overflow_c) begin
         bypass_val_c = is_rem_c ? '0 : INT_MIN;
      end
   end

   // Result selection and sign correction of the divider output
   assign raw_res_c   = op_q.is_rem ? bus.div_remainder : bus.div_quotient;
   assign res_neg_c   = op_q.is_rem ? op_q.neg_r : op_q.neg_q;
   assign fixed_res_c = res_neg_c ? (~raw_res_c + XLEN'(1)) : raw_res_c;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      wb_rd_d    = wb_rd_q;
      wb_id_d    = wb_id_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               op_d.is_rem = is_rem_c;
               op_d.neg_q  = rs1_neg_c ^ rs2_neg_c;
               op_d.neg_r  = rs1_neg_c;
               dividend_d  = mag1_c;
               divisor_d   = mag2_c;
               wb_id_d     = bus.issue_id;
               if (div_zero_c || overflow_c) begin
                  wb_rd_d = bypass_val_c;
                  state_d = S_RESULT;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.div_done) begin
               wb_rd_d = fixed_res_c;
               state_d = S_RESULT;
            end
         end
         S_RESULT: begin
            if (bus.wb_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake outputs are registered copies of the next-state decode
      ready_d = (state_d == S_IDLE);
      start_d = (state_d == S_START);
      done_d  = (state_d == S_RESULT);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         wb_rd_q    <= '0;
         wb_id_q    <= '0;
         ready_q    <= 1'b1;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         wb_rd_q    <= wb_rd_d;
         wb_id_q    <= wb_id_d;
         ready_q    <= ready_d;
         start_q    <= start_d;
         done_q     <= done_d;
      end
   end

   assign bus.issue_ready  = ready_q;
   assign bus.div_start    = start_q;
   assign bus.div_dividend = dividend_q;
   assign bus.div_divisor  = divisor_q;
   assign bus.wb_done      = done_q;
   assign bus.wb_id        = wb_id_q;
   assign bus.wb_rd        = wb_rd_q;

endmodule
